// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bundle for the sequential divider.
//   master: drives start, dividend_sign, dividend, divisor; observes results.
//   slave : the divider; drives ready, done, sign, quotient, remainder, div_zero.
interface seq_divider_if #(
    parameter int unsigned DW = 4
);
    localparam int unsigned DW_2 = 2 * DW;

    logic            start;
    logic            dividend_sign;
    logic [DW_2-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            ready;
    logic            done;
    logic            sign;
    logic [DW_2-1:0] quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;

    modport master (
        output start, dividend_sign, dividend, divisor,
        input  ready, done, sign, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend_sign, dividend, divisor,
        output ready, done, sign, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Divides a sign/magnitude dividend (DW_2 bits) by a two's-complement
// divisor (DW bits); returns quotient magnitude, remainder magnitude and
// quotient sign. Remainder sign equals the dividend sign (not output).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - seq_divider_if.slave (start/operands in, ready/done/results out)
// Optional: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor to
// DONE with div_zero=1; otherwise div_zero is tied low and a zero divisor
// runs the full sequence.
module seq_divider #(
    parameter int unsigned DW = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int unsigned DW_2 = 2 * DW;
    localparam int unsigned CW   = $clog2(DW_2 + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_done;
    logic            r_sign;
    logic [DW_2-1:0] r_quot;
    logic [DW-1:0]   r_rem;

    logic            r_dsign;
    logic [DW_2-1:0] r_dividend;
    logic [DW-1:0]   r_divisor;
    logic [DW:0]     r_dabs;
    // Only the low DW bits of the partial remainder ever feed the next trial,
    // and a restored/subtracted remainder is always < |divisor| <= 2^(DW-1).
    logic [DW-1:0]   r_prem;
    logic [DW_2-1:0] r_qsr;
    logic [CW-1:0]   r_cnt;
`ifdef DIV_ZERO_DETECT_EN
    logic            r_dz;
    logic            r_div_zero;
`endif

    logic [DW:0]     w_div_ext;
    logic [DW:0]     w_dabs;
    logic [DW:0]     w_trial;
    logic [DW:0]     w_diff;
    logic            w_ge;

    // |divisor| in DW+1 bits so the most negative value is exact
    assign w_div_ext = {r_divisor[DW-1], r_divisor};
    assign w_dabs    = r_divisor[DW-1] ? ((~w_div_ext) + (DW+1)'(1)) : w_div_ext;

    // Restoring step: shift the next dividend bit into the partial remainder
    assign w_trial = {r_prem, r_qsr[DW_2-1]};
    assign w_diff  = w_trial - r_dabs;
    assign w_ge    = (w_trial >= r_dabs);

    // Control FSM and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dsign    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_dabs     <= '0;
            r_prem     <= '0;
            r_qsr      <= '0;
            r_cnt      <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dz       <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dsign    <= bus.dividend_sign;
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                        r_ready    <= 1'b0;
                        r_state    <= S_LOAD;
`ifdef DIV_ZERO_DETECT_EN
                        r_div_zero <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    r_dabs <= w_dabs;
                    r_prem <= '0;
                    r_qsr  <= r_dividend;
                    r_cnt  <= CW'(DW_2);
`ifdef DIV_ZERO_DETECT_EN
                    if (r_divisor == '0) begin
                        r_dz    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_dz    <= 1'b0;
                        r_state <= S_CALC;
                    end
`else
                    r_state <= S_CALC;
`endif
                end
                S_CALC: begin
                    r_prem <= DW'(w_ge ? w_diff : w_trial);
                    r_qsr  <= {r_qsr[DW_2-2:0], w_ge};
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                    if (r_dz) begin
                        r_quot     <= '1;
                        r_rem      <= '0;
                        r_sign     <= r_dsign;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_quot <= r_qsr;
                        r_rem  <= r_prem;
                        r_sign <= (r_qsr != '0) & (r_dsign ^ r_divisor[DW-1]);
                    end
`else
                    r_quot <= r_qsr;
                    r_rem  <= r_prem;
                    // A zero quotient is always reported positive
                    r_sign <= (r_qsr != '0) & (r_dsign ^ r_divisor[DW-1]);
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.done      = r_done;
    assign bus.sign      = r_sign;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = r_div_zero;
`else
    assign bus.div_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, directed corner sequences and random
// operands checked against an arithmetic reference model.
module tb_seq_divider;
    localparam int unsigned DW   = 4;
    localparam int unsigned DW_2 = 2 * DW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    seq_divider_if #(.DW(DW)) bus ();

    seq_divider #(.DW(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            dsign;
        logic [DW_2-1:0] dvd;
        logic [DW-1:0]   dvs;
        logic [DW_2-1:0] q;
        logic [DW-1:0]   r;
        logic            s;
        logic            dz;
        int              lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: plain integer division on magnitudes
    function automatic vec_t model(input logic dsign, input logic [DW_2-1:0] dvd,
                                   input logic [DW-1:0] dvs);
        vec_t v;
        int   dv;
        int   ad;
        v.dsign = dsign;
        v.dvd   = dvd;
        v.dvs   = dvs;
        dv = int'($signed(dvs));
        ad = (dv < 0) ? -dv : dv;
        if (ad == 0) begin
            v.q = '1;
            v.s = dsign;
`ifdef DIV_ZERO_DETECT_EN
            v.r   = '0;
            v.dz  = 1'b1;
            v.lat = 2;
`else
            v.r   = dvd[DW-1:0];
            v.dz  = 1'b0;
            v.lat = DW_2 + 2;
`endif
        end else begin
            v.q   = DW_2'(int'(dvd) / ad);
            v.r   = DW'(int'(dvd) % ad);
            v.s   = (v.q != 0) && (dsign ^ (dv < 0));
            v.dz  = 1'b0;
            v.lat = DW_2 + 2;
        end
        return v;
    endfunction

    task automatic launch(input logic dsign, input logic [DW_2-1:0] dvd, input logic [DW-1:0] dvs);
        int guard;
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        bus.dividend_sign = dsign;
        bus.dividend      = dvd;
        bus.divisor       = dvs;
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_result(input string nm, input vec_t e);
        int busy_err;
        bit seen;
        busy_err = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.ready !== 1'b0) busy_err++;
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'(0), 32'(1));
        end else begin
            chk({nm, "_lat"}, 32'(cyc), 32'(e.lat));
            chk({nm, "_q"},   32'(bus.quotient), 32'(e.q));
            chk({nm, "_r"},   32'(bus.remainder), 32'(e.r));
            chk({nm, "_s"},   32'(bus.sign), 32'(e.s));
            chk({nm, "_dz"},  32'(bus.div_zero), 32'(e.dz));
            chk({nm, "_busy"}, 32'(busy_err), 32'(0));
            chk({nm, "_rdy"}, 32'(bus.ready), 32'(1));
            tick();
            chk({nm, "_pulse"}, 32'(bus.done), 32'(0));
        end
    endtask

    vec_t vecs[5];
    vec_t e;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;

        vecs[0] = '{1'b0, 8'd105, 4'b0111, 8'd15, 4'd0, 1'b0, 1'b0, 10};
        vecs[1] = '{1'b1, 8'd7,   4'b1111, 8'd7,  4'd0, 1'b0, 1'b0, 10};
        vecs[2] = '{1'b0, 8'd50,  4'b1000, 8'd6,  4'd2, 1'b1, 1'b0, 10};
        vecs[3] = '{1'b1, 8'd3,   4'b0101, 8'd0,  4'd3, 1'b0, 1'b0, 10};
`ifdef DIV_ZERO_DETECT_EN
        vecs[4] = '{1'b0, 8'd90,  4'b0000, 8'hFF, 4'd0, 1'b0, 1'b1, 2};
`else
        vecs[4] = '{1'b0, 8'd90,  4'b0000, 8'hFF, 4'hA, 1'b0, 1'b0, 10};
`endif

        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.dividend_sign = 1'b0;
        bus.dividend      = '0;
        bus.divisor       = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.ready), 32'(1));
        chk("rst_done",  32'(bus.done), 32'(0));
        chk("rst_q",     32'(bus.quotient), 32'(0));
        chk("rst_r",     32'(bus.remainder), 32'(0));
        chk("rst_s",     32'(bus.sign), 32'(0));
        chk("rst_dz",    32'(bus.div_zero), 32'(0));

        // Table vectors from the plan
        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].dsign, vecs[i].dvd, vecs[i].dvs);
            wait_result($sformatf("vec%0d", i), vecs[i]);
        end

        // Start pulsed during CALC with other operands is dropped
        launch(1'b0, 8'd105, 4'b0111);
        tick();
        tick();
        bus.dividend_sign = 1'b1;
        bus.dividend      = 8'd200;
        bus.divisor       = 4'b0011;
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_result("busy_start", vecs[0]);

        // Reset mid-CALC aborts with no done pulse
        launch(1'b1, 8'd50, 4'b1000);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_ready", 32'(bus.ready), 32'(1));
        chk("abort_done",  32'(bus.done), 32'(0));
        chk("abort_q",     32'(bus.quotient), 32'(0));
        chk("abort_r",     32'(bus.remainder), 32'(0));
        chk("abort_s",     32'(bus.sign), 32'(0));
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 14; i++) begin
                tick();
                if (bus.done === 1'b1) dones++;
            end
            chk("abort_no_done", 32'(dones), 32'(0));
        end
        launch(1'b0, 8'd50, 4'b1000);
        wait_result("after_abort", vecs[2]);

        // Start held high: back-to-back divisions, 11 cycles apart
        begin
            int  g;
            bit  seen;
            bus.dividend_sign = 1'b1;
            bus.dividend      = 8'd7;
            bus.divisor       = 4'b1111;
            bus.start         = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                if (bus.done === 1'b1) seen = 1'b1;
            end
            chk("hold_first", 32'(seen), 32'(1));
            g    = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                g++;
                if (bus.done === 1'b1) seen = 1'b1;
            end
            bus.start = 1'b0;
            chk("hold_gap", 32'(g), 32'(DW_2 + 3));
            chk("hold_q",   32'(bus.quotient), 32'(7));
        end
        repeat (2) tick();

        // Random operands against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic            rs;
            logic [DW_2-1:0] rd;
            logic [DW-1:0]   rv;
            rs = 1'($urandom_range(0, 1));
            rd = DW_2'($urandom);
            rv = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            e  = model(rs, rd, rv);
            launch(rs, rd, rv);
            wait_result($sformatf("rnd%0d_%0d_%0d", i, rd, rv), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
